// File: rtl/mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : mac_seq
// Description : Dot-product sequencer driving one floating-point mac unit.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_seq #(
  parameter int DATA_WIDTH  = 32,
  parameter int LEN_WIDTH   = 8,
  parameter int MAC_LATENCY = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  busy,
  output logic                  mac_stb,
  output logic                  mac_add_b_stb,
  output logic [DATA_WIDTH-1:0] mac_in_mult,
  output logic [DATA_WIDTH-1:0] mac_coeff,
  output logic [DATA_WIDTH-1:0] mac_in_add,
  input  logic [DATA_WIDTH-1:0] mac_out
);

  localparam int c_lat_w = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
  localparam logic [c_lat_w-1:0] c_lat_last = c_lat_w'(MAC_LATENCY - 1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_load = 2'd1;
  localparam logic [1:0] c_run  = 2'd2;
  localparam logic [1:0] c_done = 2'd3;

  logic [1:0]            r_state;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [c_lat_w-1:0]    r_lat_cnt;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_res_data;
  logic [DATA_WIDTH-1:0] r_in_mult;
  logic [DATA_WIDTH-1:0] r_coeff;
  logic [DATA_WIDTH-1:0] r_in_add;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= c_idle;
      r_remaining <= '0;
      r_lat_cnt   <= '0;
      r_acc       <= '0;
      r_res_data  <= '0;
      r_in_mult   <= '0;
      r_coeff     <= '0;
      r_in_add    <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (start) begin
            if (len != '0) begin
              r_remaining <= len;
              r_acc       <= '0;
              r_state     <= c_load;
            end else begin
              r_res_data <= '0;
              r_state    <= c_done;
            end
          end
        end
        c_load: begin
          // op_ready is high throughout LOAD, so op_valid alone completes the handshake
          if (op_valid) begin
            r_in_mult <= op_a;
            r_coeff   <= op_b;
            r_in_add  <= r_acc;
            r_lat_cnt <= '0;
            r_state   <= c_run;
          end
        end
        c_run: begin
          if (r_lat_cnt == c_lat_last) begin
            r_acc       <= mac_out;
            r_remaining <= r_remaining - LEN_WIDTH'(1);
            if (r_remaining == LEN_WIDTH'(1)) begin
              r_res_data <= mac_out;
              r_state    <= c_done;
            end else begin
              r_state <= c_load;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt + c_lat_w'(1);
          end
        end
        c_done: begin
          if (res_ready) begin
            r_state <= c_idle;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  // Handshake and strobe outputs are pure state decodes so an async reset clears them at once.
  assign op_ready      = (r_state == c_load);
  assign res_valid     = (r_state == c_done);
  assign busy          = (r_state != c_idle);
  assign mac_stb       = (r_state == c_run);
  assign mac_add_b_stb = (r_state == c_run);
  assign res_data      = r_res_data;
  assign mac_in_mult   = r_in_mult;
  assign mac_coeff     = r_coeff;
  assign mac_in_add    = r_in_add;

endmodule
`default_nettype wire

// File: tb/tb_mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_seq
// Description : Directed self-checking bench for mac_seq with a behavioural mac.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_seq;
  localparam int DW  = 32;
  localparam int LW  = 8;
  localparam int LAT = 20;

  localparam logic [31:0] F2  = 32'h4000_0000;
  localparam logic [31:0] F4  = 32'h4080_0000;
  localparam logic [31:0] F8  = 32'h4100_0000;
  localparam logic [31:0] F12 = 32'h4140_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [DW-1:0] op_a = '0;
  logic [DW-1:0] op_b = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic          busy;
  logic          mac_stb;
  logic          mac_add_b_stb;
  logic [DW-1:0] mac_in_mult;
  logic [DW-1:0] mac_coeff;
  logic [DW-1:0] mac_in_add;
  logic [DW-1:0] mac_out;

  int errors = 0;
  int checks = 0;

  mac_seq #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .MAC_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy),
    .mac_stb(mac_stb), .mac_add_b_stb(mac_add_b_stb),
    .mac_in_mult(mac_in_mult), .mac_coeff(mac_coeff), .mac_in_add(mac_in_add),
    .mac_out(mac_out)
  );

  always #5 clk = ~clk;

  // Behavioural mac: answer only after LAT consecutive strobe cycles, garbage before.
  int mcnt = 0;
  always @(posedge clk) mcnt <= (mac_stb && mac_add_b_stb) ? mcnt + 1 : 0;

  function automatic logic [31:0] mac_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
    if (a == F2 && b == F2) begin
      case (c)
        32'h0:   return F4;
        F4:      return F8;
        F8:      return F12;
        default: return 32'hBAD0_0000;
      endcase
    end
    return 32'hBAD0_0001;
  endfunction

  assign mac_out = (mac_stb && mac_add_b_stb && mcnt >= LAT - 1) ?
                   mac_fn(mac_in_mult, mac_coeff, mac_in_add) : 32'hDEAD_BEEF;

  int n_acc = 0;
  int n_stb = 0;
  int n_rdy = 0;
  always @(posedge clk) begin
    if (op_valid && op_ready) n_acc <= n_acc + 1;
    if (mac_stb)              n_stb <= n_stb + 1;
    if (op_ready)             n_rdy <= n_rdy + 1;
  end

  task automatic start_job(input logic [LW-1:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present a pair and hold it until accepted; w = negedges spent waiting for op_ready.
  task automatic send_pair(input logic [31:0] a, input logic [31:0] b, output int w);
    op_a = a;
    op_b = b;
    op_valid = 1'b1;
    w = 0;
    while (!op_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  // n = index of the negedge where res_valid is first seen, counting the handshake cycle as 0.
  task automatic wait_res(output int n);
    n = 1;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic take_result;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({op_ready, res_valid, mac_stb, mac_add_b_stb} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {op_ready, res_valid, mac_stb, mac_add_b_stb}); end
    checks++; if (res_data !== 32'h0) begin errors++; $display("FAIL reset_res_data got=%h exp=0", res_data); end
    checks++; if ({mac_in_mult, mac_coeff, mac_in_add} !== 96'h0) begin
      errors++; $display("FAIL reset_mac_in got=%h/%h/%h exp=0", mac_in_mult, mac_coeff, mac_in_add); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    int w, n;
    start_job(8'd1);
    checks++; if ({op_ready, busy} !== 2'b11) begin
      errors++; $display("FAIL t1_load got=%b exp=11", {op_ready, busy}); end
    send_pair(F2, F2, w);
    checks++; if (w !== 0) begin errors++; $display("FAIL t1_accept_wait got=%0d exp=0", w); end
    wait_res(n);
    checks++; if (n !== LAT + 1) begin errors++; $display("FAIL t1_latency got=%0d exp=%0d", n, LAT + 1); end
    checks++; if (res_data !== F4) begin errors++; $display("FAIL t1_result got=%h exp=%h", res_data, F4); end
    take_result();
    checks++; if ({res_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL t1_idle got=%b exp=00", {res_valid, busy}); end
  endtask

  task automatic test_two_pairs;
    int w, n;
    start_job(8'd2);
    send_pair(F2, F2, w);
    send_pair(F2, F2, w);
    checks++; if (w !== LAT) begin errors++; $display("FAIL t2_pair_spacing got=%0d exp=%0d", w, LAT); end
    checks++; if (mac_in_add !== F4) begin errors++; $display("FAIL t2_in_add got=%h exp=%h", mac_in_add, F4); end
    checks++; if ({mac_stb, mac_add_b_stb} !== 2'b11) begin
      errors++; $display("FAIL t2_strobes got=%b exp=11", {mac_stb, mac_add_b_stb}); end
    wait_res(n);
    checks++; if (res_data !== F8) begin errors++; $display("FAIL t2_result got=%h exp=%h", res_data, F8); end
    take_result();
  endtask

  task automatic test_zero_len;
    int s0, r0;
    s0 = n_stb;
    r0 = n_rdy;
    start_job(8'd0);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL t3_done got=%b exp=1", res_valid); end
    checks++; if (res_data !== 32'h0) begin errors++; $display("FAIL t3_data got=%h exp=0", res_data); end
    take_result();
    checks++; if (n_stb - s0 !== 0) begin errors++; $display("FAIL t3_stb got=%0d exp=0", n_stb - s0); end
    checks++; if (n_rdy - r0 !== 0) begin errors++; $display("FAIL t3_op_ready got=%0d exp=0", n_rdy - r0); end
  endtask

  task automatic test_stall;
    int w, n, s0;
    start_job(8'd1);
    s0 = n_stb;
    repeat (10) @(negedge clk);
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL t4_ready_hold got=%b exp=1", op_ready); end
    checks++; if (n_stb - s0 !== 0) begin errors++; $display("FAIL t4_no_stb got=%0d exp=0", n_stb - s0); end
    send_pair(F2, F2, w);
    wait_res(n);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if ({res_valid, res_data} !== {1'b1, F4}) begin
        errors++; $display("FAIL t4_hold cyc=%0d got=%b/%h exp=1/%h", i, res_valid, res_data, F4); end
    end
    take_result();
  endtask

  task automatic test_no_restart;
    int w, n, a0;
    a0 = n_acc;
    start_job(8'd2);
    send_pair(F2, F2, w);
    start = 1'b1;
    len   = 8'd5;
    @(negedge clk);
    start = 1'b0;
    // Second pair is offered immediately and held through the remainder of RUN.
    send_pair(F2, F2, w);
    wait_res(n);
    checks++; if (res_data !== F8) begin errors++; $display("FAIL t5_result got=%h exp=%h", res_data, F8); end
    take_result();
    op_valid = 1'b1;
    repeat (4) @(negedge clk);
    op_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_idle got=%b exp=0", busy); end
    checks++; if (n_acc - a0 !== 2) begin errors++; $display("FAIL t5_accepts got=%0d exp=2", n_acc - a0); end
  endtask

  task automatic test_back_to_back;
    int w, n;
    start_job(8'd1);
    send_pair(F2, F2, w);
    wait_res(n);
    res_ready = 1'b1;
    start = 1'b1;
    len = 8'd1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bb_start_ignored got=%b exp=0", busy); end
    @(negedge clk);
    start = 1'b0;
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL bb_restart got=%b exp=1", op_ready); end
    send_pair(F2, F2, w);
    wait_res(n);
    checks++; if (res_data !== F4) begin errors++; $display("FAIL bb_result got=%h exp=%h", res_data, F4); end
    take_result();
  endtask

  task automatic test_async_reset;
    int w, n;
    start_job(8'd3);
    send_pair(F2, F2, w);
    repeat (5) @(negedge clk);
    checks++; if ({busy, mac_stb} !== 2'b11) begin
      errors++; $display("FAIL t6_running got=%b exp=11", {busy, mac_stb}); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({op_ready, res_valid, busy, mac_stb, mac_add_b_stb} !== 5'b0) begin
      errors++; $display("FAIL t6_async_flags got=%b exp=00000",
                         {op_ready, res_valid, busy, mac_stb, mac_add_b_stb}); end
    checks++; if ({res_data, mac_in_mult, mac_coeff, mac_in_add} !== 128'h0) begin
      errors++; $display("FAIL t6_async_data got=%h/%h/%h/%h exp=0",
                         res_data, mac_in_mult, mac_coeff, mac_in_add); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start_job(8'd1);
    send_pair(F2, F2, w);
    wait_res(n);
    checks++; if (res_data !== F4) begin errors++; $display("FAIL t6_fresh got=%h exp=%h", res_data, F4); end
    take_result();
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_pairs();
    test_zero_len();
    test_stall();
    test_no_restart();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
